level_column_feeder: RTL

- Writer side of the scrolling block-column window: streams level columns into the 10-column block window as (new_block_id, Shift) pairs.
- Reads 3-bit block IDs one row at a time from a synchronous level ROM. Assembles each 30-bit column (10 rows × 3 bits) and pulses Shift for one cycle per column.
- After reset it preloads the first 10 columns. After that it delivers one column per scroll request, until the end of the level.

---
 rtl/level_column_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/level_column_feeder.sv
// Level column feeder: fetches 10 block IDs per column from a synchronous
// level ROM and strobes each assembled column into the scrolling window.
module level_column_feeder #(
  parameter int LEVEL_COLS = 200,
  parameter int ROWS       = 10,
  parameter int ADDR_W     = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              scroll_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [3*ROWS-1:0] new_block_id,
  output logic              Shift,
  output logic [7:0]        col_index,
  output logic              busy,
  output logic              level_end
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_CAPTURE  = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_PFETCH   = 3'd5;
  localparam logic [2:0] S_PCAPTURE = 3'd6;
  localparam logic [2:0] S_PSHIFT   = 3'd7;

  localparam logic [7:0] PRELOAD_COLS = 8'd10;
  localparam logic [7:0] LAST_COL     = 8'(LEVEL_COLS);
  localparam logic [3:0] ROW_LAST     = 4'(ROWS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [3:0]        r_row;
  logic [7:0]        r_col;
  logic              r_pending;
  logic              r_level_end;
  logic [3*ROWS-1:0] r_col_data;

  logic       w_fetch;
  logic       w_capture;
  logic       w_shift;
  logic       w_busy_req;
  logic       w_last;
  logic [7:0] w_col_inc;
  logic       w_wr;
  logic [3:0] w_slot;
  logic [7:0] w_lsb;

  assign w_fetch    = (r_state == S_FETCH) || (r_state == S_PFETCH);
  assign w_capture  = (r_state == S_CAPTURE) || (r_state == S_PCAPTURE);
  assign w_shift    = (r_state == S_SHIFT) || (r_state == S_PSHIFT);
  assign w_busy_req = (r_state == S_FETCH) || (r_state == S_CAPTURE);
  assign w_col_inc  = r_col + 8'd1;
  assign w_last     = (w_col_inc == LAST_COL);

  // ROM beat for address i lands one cycle later; row 9 lands in CAPTURE
  assign w_wr   = (w_fetch && (r_row != 4'd0)) || w_capture;
  assign w_slot = w_capture ? ROW_LAST : (r_row - 4'd1);
  assign w_lsb  = 8'(w_slot) * 8'd3;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (scroll_req)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        if (r_row == ROW_LAST)
          w_next = S_CAPTURE;
      end
      S_CAPTURE: w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last)
          w_next = S_DONE;
        else if (r_pending || scroll_req)
          w_next = S_FETCH;
        else
          w_next = S_IDLE;
      end
      S_PFETCH: begin
        if (r_row == ROW_LAST)
          w_next = S_PCAPTURE;
      end
      S_PCAPTURE: w_next = S_PSHIFT;
      S_PSHIFT: begin
        if (w_last)
          w_next = S_DONE;
        else if (w_col_inc < PRELOAD_COLS)
          w_next = S_PFETCH;
        else
          w_next = S_IDLE;
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_PFETCH;
      r_row       <= 4'd0;
      r_col       <= 8'd0;
      r_pending   <= 1'b0;
      r_level_end <= 1'b0;
      r_col_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_fetch && (r_row != ROW_LAST))
        r_row <= r_row + 4'd1;
      else
        r_row <= 4'd0;
      if (w_wr)
        r_col_data[w_lsb +: 3] <= rom_data;
      if (w_shift) begin
        r_col <= w_col_inc;
        if (w_last)
          r_level_end <= 1'b1;
      end
      // one-deep request memory; consumed or discarded when SHIFT ends
      if (w_shift)
        r_pending <= 1'b0;
      else if (scroll_req && w_busy_req)
        r_pending <= 1'b1;
    end
  end

  assign rom_addr     = ADDR_W'(r_col) * ADDR_W'(ROWS) + ADDR_W'(r_row);
  assign new_block_id = r_col_data;
  assign Shift        = w_shift;
  assign col_index    = r_col;
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign level_end    = r_level_end;

endmodule
